apb_mem_slave_param: RTL and testbench

// - Parametrised APB3/APB4 memory slave; successor to the fixed 32x32 APB memory.
// - Adds configurable data width, depth and wait states, PSTRB byte-lane writes,
//   and a registered, spec-compliant PREADY/PRDATA response.
// - Sits behind the APB bridge/decoder as a scratch RAM or register-file target.

---
 rtl/apb_mem_pkg.sv | 34 +++
 rtl/apb_mem_slave_param_if.sv | 30 +++
 rtl/apb_mem_array.sv | 32 +++
 rtl/apb_mem_slave_param.sv | 143 ++++++++++++++
 tb/tb_apb_mem_slave_param.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_mem_pkg : FSM state type, sizing helpers and default geometry          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } apb_mem_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index width never collapses to zero so a DEPTH=1 RAM still has a port.
  function automatic int idx_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;
  localparam int STRB_W         = DEF_DATA_WIDTH / 8;
  localparam int IDX_W          = idx_w(DEF_DEPTH);

endpackage
`default_nettype wire

// File: rtl/apb_mem_slave_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_mem_slave_param_if : APB3/APB4 bus bundle with master/slave views      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface apb_mem_slave_param_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_mem_array : single-port RAM, byte-enable write, registered read        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_WIDTH/8-1:0]    be,
  input  logic [idx_w(DEPTH)-1:0]    idx,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);
  localparam int c_strb_w = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (be[b]) r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= r_mem[idx];
  end
endmodule
`default_nettype wire

// File: rtl/apb_mem_slave_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_mem_slave_param : parametrised APB memory slave with wait states and   |
// | PSTRB lanes; APB_MEM_SLVERR_EN enables range/alignment error responses.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_mem_slave_param
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  prst,
  apb_mem_slave_param_if.slave  bus
);
  localparam int              c_strb_w = DATA_WIDTH / 8;
  localparam int              c_lsb    = clog2(c_strb_w);
  localparam int              c_idx_w  = idx_w(DEPTH);
  localparam int              c_word_w = ADDR_WIDTH - c_lsb;
  localparam logic [3:0]      c_wait   = 4'(WAIT_STATES);

  apb_mem_state_t        r_state;
  logic [3:0]            r_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_strb_w-1:0]   r_strb;
  logic                  r_err;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_rd_valid;

  logic [c_word_w-1:0]   w_word;
  logic [c_idx_w-1:0]    w_idx;
  logic                  w_err;
  logic [c_idx_w-1:0]    w_mem_idx;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_word = bus.paddr[ADDR_WIDTH-1:c_lsb];

`ifdef APB_MEM_SLVERR_EN
  localparam logic [c_word_w:0] c_depth = (c_word_w + 1)'(DEPTH);
  logic w_misalign;

  generate
    if (c_lsb > 0) begin : g_align
      assign w_misalign = |bus.paddr[c_lsb-1:0];
    end else begin : g_no_align
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_err = ({1'b0, w_word} >= c_depth) || w_misalign;
  assign w_idx = c_idx_w'(w_word);
`else
  generate
    if (c_lsb > 0) begin : g_unused_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^bus.paddr[c_lsb-1:0];
    end
  endgenerate

  assign w_err = 1'b0;
  assign w_idx = c_idx_w'(w_word % DEPTH);
`endif

  // RAM reads the live bus address during setup so zero-wait reads have data in ACC.
  assign w_mem_idx = (r_state == IDLE) ? w_idx : r_idx;
  assign w_we      = (r_state == ACC) && r_write && !r_err && !prst;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (pclk),
    .we    (w_we),
    .be    (r_strb),
    .idx   (w_mem_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_rd_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            r_idx   <= w_idx;
            r_write <= bus.pwrite;
            r_wdata <= bus.pwdata;
            r_strb  <= bus.pstrb;
            r_err   <= w_err;
            r_cnt   <= c_wait;
            if (WAIT_STATES == 0) begin
              r_state    <= ACC;
              r_pready   <= 1'b1;
              r_pslverr  <= w_err;
              r_rd_valid <= !bus.pwrite && !w_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (!bus.psel || !bus.penable) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state    <= ACC;
            r_pready   <= 1'b1;
            r_pslverr  <= r_err;
            r_rd_valid <= !r_write && !r_err;
          end
        end
        ACC: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.prdata  = r_rd_valid ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_mem_slave_param : zero-wait and 3-wait instances against a          |
// | word-array reference model. Rev 1.0                                        |
// +----------------------------------------------------------------------------+
module tb_apb_mem_slave_param;

  logic        clk;
  logic        prst;
  logic        sel;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] mdl [2][64];

  apb_mem_slave_param_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if0 ();
  apb_mem_slave_param_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if1 ();

  assign if0.psel    = psel & ~sel;
  assign if1.psel    = psel & sel;
  assign if0.penable = penable;
  assign if1.penable = penable;
  assign if0.pwrite  = pwrite;
  assign if1.pwrite  = pwrite;
  assign if0.paddr   = paddr;
  assign if1.paddr   = paddr;
  assign if0.pwdata  = pwdata;
  assign if1.pwdata  = pwdata;
  assign if0.pstrb   = pstrb;
  assign if1.pstrb   = pstrb;

  apb_mem_slave_param #(
    .DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(12), .WAIT_STATES(0)
  ) dut0 (
    .pclk(clk), .prst(prst), .bus(if0.slave)
  );

  apb_mem_slave_param #(
    .DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(12), .WAIT_STATES(3)
  ) dut1 (
    .pclk(clk), .prst(prst), .bus(if1.slave)
  );

  wire        rdy = sel ? if1.pready  : if0.pready;
  wire [31:0] rd  = sel ? if1.prdata  : if0.prdata;
  wire        err = sel ? if1.pslverr : if0.pslverr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_err(input logic [11:0] a);
`ifdef APB_MEM_SLVERR_EN
    return (int'(a >> 2) >= 64) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mdl_idx(input logic [11:0] a);
    return int'(a >> 2) % 64;
  endfunction

  // One APB transfer; drop_at>0 lowers penable in that access cycle,
  // rst_acc asserts reset during the ready cycle.
  task automatic xfer(input bit s, input logic [11:0] a, input bit w,
                      input logic [31:0] d, input logic [3:0] st,
                      input int drop_at, input bit rst_acc);
    int          ws;
    int          idx;
    bit          e;
    logic [31:0] exp_rd;
    ws     = s ? 3 : 0;
    idx    = mdl_idx(a);
    e      = mdl_err(a);
    exp_rd = (w || e) ? 32'd0 : mdl[s][idx];
    @(negedge clk);
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    paddr   = 12'($urandom);
    pwdata  = $urandom;
    pstrb   = 4'($urandom);
    for (int cyc = 1; cyc <= ws + 1; cyc++) begin
      chk("pready_timing", 32'(rdy), 32'(cyc == ws + 1));
      if (cyc == drop_at) begin
        penable = 1'b0;
        @(negedge clk);
        psel = 1'b0;
        chk("pready_after_abort", 32'(rdy), 32'd0);
        return;
      end
      if (cyc == ws + 1) begin
        chk("prdata", rd, exp_rd);
        chk("pslverr", 32'(err), 32'(e));
        if (rst_acc) begin
          prst = 1'b1;
          @(negedge clk);
          chk("rst_pready", 32'(rdy), 32'd0);
          chk("rst_prdata", rd, 32'd0);
          chk("rst_pslverr", 32'(err), 32'd0);
          prst = 1'b0; psel = 1'b0; penable = 1'b0;
          return;
        end
        if (w && !e) begin
          for (int b = 0; b < 4; b++) begin
            if (st[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
          end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", 32'(rdy), 32'd0);
        chk("prdata_idle_zero", rd, 32'd0);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [11:0] a;
    bit          s;
    int          drop;
    prst = 1'b1; sel = 1'b0; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b0; paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_pready0",  32'(if0.pready),  32'd0);
      chk("reset_prdata0",  if0.prdata,       32'd0);
      chk("reset_pslverr0", 32'(if0.pslverr), 32'd0);
      chk("reset_pready1",  32'(if1.pready),  32'd0);
      chk("reset_prdata1",  if1.prdata,       32'd0);
    end
    prst = 1'b0; psel = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        xfer(d[0], 12'(i * 4), 1'b1, $urandom, 4'hF, 0, 1'b0);
      end
    end

    xfer(1'b0, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    xfer(1'b0, 12'h010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    chk("deadbeef_model", mdl[0][4], 32'hDEADBEEF);

    xfer(1'b0, 12'h014, 1'b1, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    xfer(1'b0, 12'h014, 1'b1, 32'h00AA0000, 4'b0100, 0, 1'b0);
    xfer(1'b0, 12'h014, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    xfer(1'b0, 12'h014, 1'b1, 32'h12121212, 4'b0000, 0, 1'b0);
    xfer(1'b0, 12'h014, 1'b0, 32'h0, 4'h0, 0, 1'b0);

    xfer(1'b1, 12'h030, 1'b1, 32'h12345678, 4'hF, 0, 1'b0);
    xfer(1'b1, 12'h030, 1'b1, 32'hCAFEF00D, 4'hF, 2, 1'b0);
    xfer(1'b1, 12'h030, 1'b0, 32'h0, 4'h0, 0, 1'b0);

    xfer(1'b0, 12'h100, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    xfer(1'b0, 12'h100, 1'b1, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
    xfer(1'b0, 12'h000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    xfer(1'b0, 12'h102, 1'b1, 32'h5A5A5A5A, 4'hF, 0, 1'b0);
    xfer(1'b0, 12'h000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    xfer(1'b1, 12'h105, 1'b1, 32'h77777777, 4'hF, 0, 1'b0);
    xfer(1'b1, 12'h004, 1'b0, 32'h0, 4'h0, 0, 1'b0);

    xfer(1'b0, 12'h020, 1'b1, 32'h55AA55AA, 4'hF, 0, 1'b1);
    xfer(1'b0, 12'h020, 1'b0, 32'h0, 4'h0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      s    = 1'($urandom);
      a    = ($urandom_range(0, 9) < 7) ? 12'($urandom_range(0, 63) * 4) : 12'($urandom);
      drop = (s && $urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      xfer(s, a, 1'($urandom), $urandom, 4'($urandom), drop, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
